// File: rtl/mult_seq_ctrl_if.sv
// Handshake and data bundle between issue logic and the sequential multiplier.
// The slave modport is the multiplier side; the master modport is the requester side.
interface mult_seq_ctrl_if #(
  parameter int WIDTH = 8
) ();
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, product
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequential signed/unsigned multiplier: one partial-product row per cycle,
// modified Baugh-Wooley toggling plus a preloaded correction constant.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mult_seq_ctrl_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [CW-1:0]      j_q, j_d;
  logic [PW-1:0]      acc_q, acc_d;
  logic [PW-1:0]      prod_q, prod_d;

  logic               last_row;
  logic [WIDTH-1:0]   row;
  logic [PW-1:0]      sum;
  logic [PW-1:0]      corr;

  assign last_row = (j_q == CW'(WIDTH - 1));

  // Row toggling: invert a[W-1]&b[j] for j<W-1 and a[i]&b[W-1] for i<W-1;
  // the top-corner bit is toggled twice and therefore left as is.
  always_comb begin
    row = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      row[i] = (a_q[i] & b_q[j_q]) ^ (sgn_q & ((i == WIDTH - 1) ^ last_row));
    end
  end

  assign sum  = acc_q + (PW'(row) << j_q);
  assign corr = bus.is_signed ? ((PW'(1) << WIDTH) | (PW'(1) << (PW - 1))) : '0;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    j_d     = j_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          sgn_d   = bus.is_signed;
          j_d     = '0;
          acc_d   = corr;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sum;
        j_d   = j_q + CW'(1);
        if (last_row) begin
          state_d = DONE;
          prod_d  = sum;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      j_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = prod_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: the driver queues expected products,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_seq_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mult_seq_ctrl_if #(.WIDTH(W)) bus ();

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2*W-1:0] prod;
    int             due;
  } exp_t;

  exp_t           sb[$];
  int             done_cycles[$];
  int             checks = 0;
  int             errors = 0;
  int             ncyc = 0;
  int             busy_run = 0;
  logic           prev_busy = 1'b0;
  logic [2*W-1:0] last_prod = '0;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    longint xi, yi, p;
    logic [63:0] pv;
    xi = s ? longint'($signed(x)) : longint'(x);
    yi = s ? longint'($signed(y)) : longint'(y);
    p  = xi * yi;
    pv = p;
    return pv[2*W-1:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, ncyc);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (rst_n) begin
        check("done_busy_excl", {63'b0, bus.done & bus.busy}, 64'd0);
        if (bus.done) begin
          done_cycles.push_back(ncyc);
          if (sb.size() == 0) begin
            check("unexpected_done", {63'b0, bus.done}, 64'd0);
          end else begin
            e = sb.pop_front();
            check("product", 64'(bus.product), 64'(e.prod));
            check("latency", 64'(ncyc), 64'(e.due));
          end
          last_prod = bus.product;
        end else begin
          check("product_hold", 64'(bus.product), 64'(last_prod));
        end
        if (prev_busy && !bus.busy) check("busy_len", 64'(busy_run), 64'(W));
        busy_run  = bus.busy ? busy_run + 1 : 0;
        prev_busy = bus.busy;
      end
    end
  end

  // Called at negedge+1; leaves start high so back-to-back issue is possible.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int t = 0;
    while (bus.busy && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    if (t >= 50) check("issue_timeout", {63'b0, bus.busy}, 64'd0);
    bus.a         = x;
    bus.b         = y;
    bus.is_signed = s;
    bus.start     = 1'b1;
    sb.push_back('{prod: ref_mul(x, y, s), due: ncyc + W + 1});
    @(negedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin
      @(negedge clk); #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    bus.start = 1'b0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk); #1;
      t++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  logic [W-1:0] sa [4] = '{8'h80, 8'hFF, 8'h7F, 8'h00};
  logic [W-1:0] sbv[4] = '{8'h80, 8'h01, 8'h80, 8'h80};

  initial begin
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    #3;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_product", 64'(bus.product), 64'd0);
    #20 rst_n = 1'b1;
    @(negedge clk); #1;

    // Unsigned max
    issue(8'hFF, 8'hFF, 1'b0);
    drain();
    idle(2);

    // Signed corners
    for (int k = 0; k < 4; k++) begin
      issue(sa[k], sbv[k], 1'b1);
      drain();
      idle(1);
    end

    // Same bits, both interpretations; product holds between dones
    issue(8'hFF, 8'h80, 1'b0);
    drain();
    idle(4);
    issue(8'hFF, 8'h80, 1'b1);
    drain();
    idle(2);

    // Start during RUN is ignored
    issue(8'h03, 8'h05, 1'b0);
    idle(2);
    bus.a     = 8'h10;
    bus.b     = 8'h10;
    bus.start = 1'b1;
    @(negedge clk); #1;
    drain();
    idle(4);

    // Back-to-back with start held
    issue(8'h02, 8'h03, 1'b0);
    issue(8'h04, 8'h05, 1'b0);
    drain();
    if (done_cycles.size() >= 2)
      check("b2b_spacing", 64'(done_cycles[$] - done_cycles[$-1]), 64'(W + 1));
    idle(2);

    // Reset in the middle of a signed operation
    issue(8'h80, 8'h7F, 1'b1);
    bus.start = 1'b0;
    @(negedge clk); #6;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'b0, bus.busy}, 64'd0);
    check("midrst_done", {63'b0, bus.done}, 64'd0);
    check("midrst_product", 64'(bus.product), 64'd0);
    sb.delete();
    last_prod = '0;
    busy_run  = 0;
    prev_busy = 1'b0;
    @(negedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk); #1;
    idle(12);
    issue(8'h0A, 8'h0B, 1'b0);
    drain();
    idle(2);

    // Randomized traffic, occasionally back-to-back
    repeat (40) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    drain();
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Sequential signed/unsigned multiplier controller. It reuses a single row of `fulladder_xor` cells over `WIDTH` cycles, generating one partial-product row per cycle. The controller drives the per-cell `toggle` inputs with the modified Baugh-Wooley rule and injects the correction constants. It sits between the core's issue logic and the result bus, replacing the fully unrolled array multiplier where area matters more than latency.

## Interface

Parameters:
- `WIDTH`, default 8: operand width in bits, ≥ 2. Product width is 2*`WIDTH`.

Ports:
- `clk` (in, 1): clock, rising-edge.
- `rst_n` (in, 1): asynchronous, active-low reset.
- `start` (in, 1): request a multiply; sampled on rising `clk`.
- `a` (in, `WIDTH`): multiplicand; captured when `start` is accepted.
- `b` (in, `WIDTH`): multiplier; captured when `start` is accepted.
- `is_signed` (in, 1): 1 = two's-complement operands, 0 = unsigned; captured with the operands.
- `busy` (out, 1): high while the state is RUN.
- `done` (out, 1): one-cycle pulse; `product` is valid from this cycle.
- `product` (out, 2*`WIDTH`): result; holds its value until the next completion.

Clocking and reset are fixed: one clock `clk`; reset `rst_n` is asynchronous and active-low.

## Operation

- **State machine.** Three states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → RUN while the row counter `j` < `WIDTH`-1.
  - RUN → DONE on `j` == `WIDTH`-1.
  - DONE → RUN on `start`.
  - DONE → IDLE otherwise.
- **Start acceptance.** `start` is accepted only in IDLE or DONE. In RUN it is ignored: no capture and no effect on the operation in flight.
- **On accept:**
  - Capture `a`, `b` and `is_signed`.
  - Set `j` = 0.
  - Load the accumulator with the correction constant: if `is_signed`, 2^`WIDTH` + 2^(2*`WIDTH`-1); otherwise 0.
- **Each RUN cycle** processes row `j`:
  - Partial-product bit for cell `i` = `a[i]` & `b[j]`.
  - `toggle[i]` = `is_signed` & ((`i` == `WIDTH`-1) ^ (`j` == `WIDTH`-1)). Bit `a[W-1]`·`b[W-1]` is therefore not inverted.
  - accumulator += (toggled row) << `j`, modulo 2^(2*`WIDTH`).
  - `j` += 1.
- **Arithmetic.** The result equals the exact 2*`WIDTH`-bit product of the captured operands under the selected interpretation. Carries out of bit 2*`WIDTH`-1 are discarded.
- **`product` register.** Loaded from the final accumulator value on the RUN → DONE edge only. It never shows intermediate sums.
- **Reset values.** Reset forces state IDLE, `busy`=0, `done`=0, `product`=0, accumulator=0 and `j`=0. It takes effect immediately, including mid-RUN: the operation in flight is abandoned and no `done` is produced for it.
- **Operand changes.** Changes on `a`, `b` or `is_signed` after the accepting edge have no effect on the current operation.

## Timing

- **Latency.** With `start` accepted at edge E0:
  - `busy`=1 after E0 through edge E`WIDTH`.
  - Row `j` is accumulated at edge E(`j`+1).
  - `done`=1 and the new `product` appear after E`WIDTH`, i.e. `WIDTH` cycles after the accepting edge.
- **`done` width.** Exactly one cycle per accepted operation.
- **Back-to-back operation.** `start` held high during the DONE cycle starts the next operation at that edge, giving a throughput of one result per `WIDTH`+1 cycles. `done` and `busy` are then never high together, and `busy` rises in the cycle after `done`.
- **`start` held continuously.** This produces a new operation every `WIDTH`+1 cycles; operands are sampled at each accepting edge.
- **Output timing.** All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

All scenarios use `WIDTH`=8.

1. **Unsigned multiply.** `is_signed`=0, `a`=0xFF, `b`=0xFF, pulse `start` → `busy` high for 8 cycles, then `done` pulses once with `product`=0xFE01.
2. **Signed corner cases**, `is_signed`=1:
   - 0x80 × 0x80 → 0x4000
   - 0xFF × 0x01 → 0xFFFF
   - 0x7F × 0x80 → 0xC080
   - 0x00 × 0x80 → 0x0000
3. **Same bits, different interpretation.** `a`=0xFF, `b`=0x80:
   - `is_signed`=0 → 0x7F80.
   - `is_signed`=1 → 0x0080.
   - `product` holds 0x7F80 until the second `done`.
4. **Start during RUN is ignored.** Start 0x03 × 0x05 (unsigned), then pulse `start` with 0x10 × 0x10 at cycle 3 of RUN → only one `done`, with `product`=0x000F. `busy` stays high for exactly 8 cycles.
5. **Back-to-back.** Hold `start` with 0x02 × 0x03, then 0x04 × 0x05 presented in the DONE cycle:
   - First `done` shows 0x0006.
   - Second `done` shows 0x0014, exactly 9 cycles after the first.
6. **Reset mid-operation.** Assert `rst_n`=0 asynchronously (between clock edges) during RUN of signed 0x80 × 0x7F:
   - Outputs go to `busy`=0, `done`=0, `product`=0 immediately.
   - After release, no `done` appears until a new `start`.
   - A following unsigned 0x0A × 0x0B yields 0x006E.
